mem_arbiter: RTL

MEM_ARBITER -- requirements
Module: mem_arbiter

---
 rtl/mem_arbiter.sv | 161 ++++++++++++++++
 1 files changed

// File: rtl/mem_arbiter.sv
// mem_arbiter: round-robin arbiter sharing one fixed-latency memory port
// between an instruction-fetch requester and a load/store requester.
//
// state    | meaning
// ---------+----------------------------------------------------------
// S_IDLE   | sampling if_req/d_req, no transaction in flight
// S_ACCESS | mem_en strobe and winner's gnt, one cycle
// S_WAIT   | memory latency; rdata captured on the last WAIT cycle
// S_RESP   | owner's rvalid pulse, then back to IDLE
module mem_arbiter #(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int MEM_LAT = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic              if_gnt,
    output logic              if_rvalid,
    output logic [DATA_W-1:0] if_rdata,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic              d_gnt,
    output logic              d_rvalid,
    output logic [DATA_W-1:0] d_rdata,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              busy,
    output logic [15:0]       conflict_cnt
);

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_ACCESS = 2'd1;
    localparam logic [1:0] S_WAIT   = 2'd2;
    localparam logic [1:0] S_RESP   = 2'd3;

    localparam logic OWN_IF = 1'b0;
    localparam logic OWN_D  = 1'b1;

    // WAIT lasts MEM_LAT cycles: load MEM_LAT-1 and finish on terminal count 0
    localparam logic [2:0] WAIT_LOAD = 3'(MEM_LAT - 1);

    logic [1:0] state;
    logic       owner;
    logic       cap_we;
    logic [2:0] wait_cnt;
    logic       grant_if;
    logic       grant_d;

    // Round-robin pick: a tie goes to the port that did not own the last transaction
    always_comb begin
        grant_if = 1'b0;
        grant_d  = 1'b0;
        if (if_req && d_req) begin
            if (owner == OWN_D) begin
                grant_if = 1'b1;
            end else begin
                grant_d = 1'b1;
            end
        end else if (if_req) begin
            grant_if = 1'b1;
        end else if (d_req) begin
            grant_d = 1'b1;
        end
    end

    // Transaction FSM with all handshake outputs registered
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= S_IDLE;
            owner     <= OWN_D;
            cap_we    <= 1'b0;
            wait_cnt  <= 3'd0;
            if_gnt    <= 1'b0;
            d_gnt     <= 1'b0;
            if_rvalid <= 1'b0;
            d_rvalid  <= 1'b0;
            if_rdata  <= '0;
            d_rdata   <= '0;
            mem_en    <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            busy      <= 1'b0;
        end else begin
            if_gnt    <= 1'b0;
            d_gnt     <= 1'b0;
            if_rvalid <= 1'b0;
            d_rvalid  <= 1'b0;
            mem_en    <= 1'b0;
            mem_we    <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (grant_if || grant_d) begin
                        state  <= S_ACCESS;
                        busy   <= 1'b1;
                        mem_en <= 1'b1;
                        if (grant_d) begin
                            owner     <= OWN_D;
                            cap_we    <= d_we;
                            mem_we    <= d_we;
                            mem_addr  <= d_addr;
                            mem_wdata <= d_wdata;
                            d_gnt     <= 1'b1;
                        end else begin
                            owner     <= OWN_IF;
                            cap_we    <= 1'b0;
                            mem_addr  <= if_addr;
                            mem_wdata <= '0;
                            if_gnt    <= 1'b1;
                        end
                    end
                end
                S_ACCESS: begin
                    state    <= S_WAIT;
                    wait_cnt <= WAIT_LOAD;
                end
                S_WAIT: begin
                    if (wait_cnt == 3'd0) begin
                        state <= S_RESP;
                        if (owner == OWN_IF) begin
                            if_rdata  <= mem_rdata;
                            if_rvalid <= 1'b1;
                        end else begin
                            d_rvalid <= 1'b1;
                            if (!cap_we) begin
                                d_rdata <= mem_rdata;
                            end
                        end
                    end else begin
                        wait_cnt <= wait_cnt - 3'd1;
                    end
                end
                S_RESP: begin
                    state <= S_IDLE;
                    busy  <= 1'b0;
                end
                default: begin
                    state <= S_IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

    // Saturating count of IDLE cycles with both requesters pending
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            conflict_cnt <= '0;
        end else if (state == S_IDLE && if_req && d_req && conflict_cnt != 16'hFFFF) begin
            conflict_cnt <= conflict_cnt + 16'd1;
        end
    end

endmodule
